// File: rtl/poisonninja_top.sv
// poisonninja_top: fixed-period PWM generator for an 8-in/8-out pad frame.
// The pad frame carries the clock, the reset and a 6-bit duty value.
// io_in[0] is the clock, io_in[1] is a synchronous active-high reset,
// and io_in[7:2] is the duty value.
// A free-running counter spans one PERIOD-cycle frame.
// Three values leave on io_out, and all of them are registered:
//   io_out[0]   : pwm, high while the counter is below the duty value
//   io_out[1]   : strobe, high for the phase-0 slot of each frame
//   io_out[7:2] : phase, the counter value that produced this pwm/strobe
// The duty value is compared live every cycle and has no shadow register.
// Keeping frames glitch-free is therefore left to whoever drives io_in.

module poisonninja_top #(
    parameter int PERIOD = 50,
    parameter int CNT_W  = 6
) (
    input  logic [7:0] io_in,
    output logic [7:0] io_out
);

    // Last counter value of a frame, sized to the counter width.
    localparam logic [CNT_W-1:0] LAST_PHASE = CNT_W'(PERIOD - 1);

    // Pad-frame unpacking.
    logic             clk_s;
    logic             rst_s;
    logic [CNT_W-1:0] duty_s;

    assign clk_s  = io_in[0];
    assign rst_s  = io_in[1];
    assign duty_s = io_in[7:2];

    // State and registered outputs.
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             pwm_q;
    logic             pwm_d;
    logic             strobe_q;
    logic             strobe_d;
    logic [CNT_W-1:0] phase_q;
    logic [CNT_W-1:0] phase_d;

    // Next-state logic: advance or wrap the frame counter, and derive the outputs for the current phase.
    always_comb begin
        pwm_d    = (cnt_q < duty_s);
        strobe_d = (cnt_q == {CNT_W{1'b0}});
        phase_d  = cnt_q;
        if (cnt_q == LAST_PHASE) begin
            cnt_d = {CNT_W{1'b0}};
        end else begin
            cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    // Register update; the synchronous reset overrides every other update.
    always_ff @(posedge clk_s) begin
        if (rst_s) begin
            cnt_q    <= {CNT_W{1'b0}};
            pwm_q    <= 1'b0;
            strobe_q <= 1'b0;
            phase_q  <= {CNT_W{1'b0}};
        end else begin
            cnt_q    <= cnt_d;
            pwm_q    <= pwm_d;
            strobe_q <= strobe_d;
            phase_q  <= phase_d;
        end
    end

    assign io_out = {phase_q, strobe_q, pwm_q};

endmodule

// File: tb/tb_poisonninja_top.sv
// tb_poisonninja_top: directed self-checking bench for the PWM generator.
// After each reset, the bench tracks the frame phase it expects to see.
// It derives the expected io_out from that phase and the duty value it drives.

module tb_poisonninja_top;

    localparam int PERIOD = 50;

    logic       clk;
    logic       rst;
    logic [5:0] duty;
    logic [7:0] io_in;
    logic [7:0] io_out;

    int n_cmp;
    int n_bad;
    int exp_phase;

    assign io_in = {duty, rst, clk};

    poisonninja_top #(.PERIOD(50), .CNT_W(6)) dut (
        .io_in  (io_in),
        .io_out (io_out)
    );

    // Free-running clock with a 10-unit period.
    always #5 clk = ~clk;

    // Single compare point: counts the comparison and reports any difference.
    task automatic chk_eq(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp = n_cmp + 1;
        if (obs !== exp) begin
            n_bad = n_bad + 1;
            $display("FAIL %s: got %02h expected %02h", tag, obs, exp);
        end
    endtask

    // Hold reset for n edges and check that the outputs are zero after each edge.
    // Then release reset and restart the expected phase at 0.
    task automatic do_reset(input string tag, input int n);
        rst = 1'b1;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            chk_eq(tag, io_out, 8'h00);
        end
        rst = 1'b0;
        exp_phase = 0;
    endtask

    // Run n edges and check io_out after each edge.
    // The expected value is {phase, phase==0, phase<duty}.
    task automatic run_edges(input string tag, input int n);
        logic [7:0] exp;
        logic [5:0] ph;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            ph  = 6'(exp_phase);
            exp = {ph, (exp_phase == 0), (exp_phase < int'(duty))};
            chk_eq(tag, io_out, exp);
            exp_phase = (exp_phase == PERIOD - 1) ? 0 : exp_phase + 1;
        end
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        exp_phase = 0;
        clk  = 1'b0;
        rst  = 1'b1;
        duty = 6'd0;

        // duty=25: one frame, 25 high and then 25 low.
        duty = 6'd25;
        do_reset("rst_d25", 1);
        run_edges("d25", 50);

        // duty=10: two frames, with the phase wrapping 49 -> 0.
        duty = 6'd10;
        do_reset("rst_d10", 1);
        run_edges("d10", 100);

        // Saturation: 50 and 60 both keep the output high.
        duty = 6'd50;
        do_reset("rst_d50", 1);
        run_edges("d50", 100);
        duty = 6'd60;
        do_reset("rst_d60", 1);
        run_edges("d60", 100);

        // duty=0: the output never goes high, but the strobe keeps pulsing.
        duty = 6'd0;
        do_reset("rst_d0", 1);
        run_edges("d0", 100);

        // Reset mid-frame at phase 30.
        // The outputs stay zero while reset is held, then a full frame restarts.
        duty = 6'd25;
        do_reset("rst_mid0", 1);
        run_edges("mid_pre", 31);
        do_reset("rst_mid_hold", 3);
        run_edges("mid_post", 50);

        // Duty is switched from 25 to 40 after the phase-30 edge.
        // The output goes high again on the next edge and stays high through phase 39.
        duty = 6'd25;
        do_reset("rst_sw", 1);
        run_edges("sw_pre", 31);
        duty = 6'd40;
        run_edges("sw_post", 19);
        run_edges("sw_next", 50);

        // Hand-written spot checks after the switch test.
        // The previous run_edges call finished on phase 49, so the next edge is phase 0 with duty 40.
        @(posedge clk);
        #1;
        chk_eq("spot_ph0", io_out, 8'b000000_1_1);
        @(posedge clk);
        #1;
        chk_eq("spot_ph1", io_out, 8'b000001_0_1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
